// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state type and constants for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} pll_sup_state_t;

  localparam logic [7:0] CNT8_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - generic multi-flop bit synchronizer with async active-high reset to 0
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - drives PLL reset, debounces lock and gates the core reset
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 5_000_000,
  parameter int STABLE_CYCLES = 50_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] timeout_cnt,
  output logic [7:0] relock_cnt
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);

  // Down-counter reload values: each state lasts exactly its parameter in cycles.
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LOAD  = CNT_W'(STABLE_CYCLES - 1);

  logic locked_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  pll_sup_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       timeout_cnt_q, timeout_cnt_d;
  logic [7:0]       relock_cnt_q, relock_cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    relock_cnt_d  = relock_cnt_q;
    lock_lost_d   = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = ST_LOAD;
        end else if (cnt_q == '0) begin
          state_d       = RESET_PLL;
          cnt_d         = RST_LOAD;
          timeout_cnt_d = sat_inc8(timeout_cnt_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d      = RESET_PLL;
          cnt_d        = RST_LOAD;
          lock_lost_d  = 1'b1;
          relock_cnt_d = sat_inc8(relock_cnt_q);
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = RST_LOAD;
      end
    endcase
    // Outputs follow the next state so they change on the same edge as the FSM.
    pll_rst_d  = (state_d == RESET_PLL);
    core_rst_d = (state_d != RUN);
    ready_d    = (state_d == RUN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_PLL;
      cnt_q         <= RST_LOAD;
      timeout_cnt_q <= '0;
      relock_cnt_q  <= '0;
      pll_rst_q     <= 1'b1;
      core_rst_q    <= 1'b1;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      relock_cnt_q  <= relock_cnt_d;
      pll_rst_q     <= pll_rst_d;
      core_rst_q    <= core_rst_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_rst    = core_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign timeout_cnt = timeout_cnt_q;
  assign relock_cnt  = relock_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor with shortened timings
module tb_pll_lock_supervisor;

  localparam int EV_LL    = 0;
  localparam int EV_READY = 1;
  localparam int EV_TO    = 2;

  typedef struct {
    int kind;
    int tcnt;
    int rcnt;
    int rise;
  } exp_t;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] timeout_cnt;
  logic [7:0] relock_cnt;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .core_rst    (core_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .timeout_cnt (timeout_cnt),
    .relock_cnt  (relock_cnt)
  );

  always #5 refclk = ~refclk;

  initial forever begin
    @(posedge refclk);
    cyc++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int t, input int r, input int rise);
    exp_t e;
    e.kind = kind;
    e.tcnt = t;
    e.rcnt = r;
    e.rise = rise;
    sb_q.push_back(e);
  endtask

  task automatic on_event(input int kind);
    exp_t e;
    int   lat;
    if (sb_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
      return;
    end
    e = sb_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("relock_cnt", int'(relock_cnt), e.rcnt);
    chk("timeout_cnt", int'(timeout_cnt), e.tcnt);
    case (kind)
      EV_LL: begin
        chk("ll_core_rst", int'(core_rst), 1);
        chk("ll_pll_rst", int'(pll_rst), 1);
        chk("ll_ready", int'(ready), 0);
      end
      EV_READY: begin
        chk("run_core_rst", int'(core_rst), 0);
        if (e.rise >= 0) begin
          lat = cyc - e.rise;
          n_chk++;
          if (lat < 10 || lat > 12) begin
            n_fail++;
            $display("FAIL ready_latency: got %0d cycles, required 11 +/-1", lat);
          end
        end
      end
      default: begin
        chk("to_pll_rst", int'(pll_rst), 1);
        chk("to_core_rst", int'(core_rst), 1);
      end
    endcase
  endtask

  // Monitor: reacts to DUT-originated events and checks them against the queue.
  initial begin
    logic prev_ready;
    logic prev_ll;
    int   prev_tcnt;
    prev_ready = 1'b0;
    prev_ll    = 1'b0;
    prev_tcnt  = 0;
    forever begin
      @(negedge refclk);
      if (rst) begin
        prev_ready = 1'b0;
        prev_ll    = 1'b0;
        prev_tcnt  = 0;
      end else begin
        if (prev_ll) chk("lock_lost_one_cycle", int'(lock_lost), 0);
        if (lock_lost) on_event(EV_LL);
        if (ready && !prev_ready) on_event(EV_READY);
        if (int'(timeout_cnt) != prev_tcnt) on_event(EV_TO);
        prev_ready = ready;
        prev_ll    = lock_lost;
        prev_tcnt  = int'(timeout_cnt);
      end
    end
  end

  task automatic do_reset(input string tag);
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk({tag, "_pll_rst"}, int'(pll_rst), 1);
    chk({tag, "_core_rst"}, int'(core_rst), 1);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_lock_lost"}, int'(lock_lost), 0);
    chk({tag, "_timeout_cnt"}, int'(timeout_cnt), 0);
    chk({tag, "_relock_cnt"}, int'(relock_cnt), 0);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int k;
    k = 0;
    while (!ready && k < bound) begin
      @(negedge refclk);
      k++;
    end
    chk({tag, "_ready_reached"}, int'(ready), 1);
  endtask

  initial begin
    int n_hi;
    int core_ok;
    int rises;
    int prev_p;
    int r_exp;

    // T1: reset, then PLL reset pulse of exactly 4 cycles
    do_reset("t1_reset");
    n_hi    = 0;
    core_ok = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge refclk);
      n_hi++;
      @(negedge refclk);
      if (!core_rst) core_ok = 0;
      if (!pll_rst) break;
    end
    chk("t1_pll_rst_cycles", n_hi, 4);
    chk("t1_core_rst_held", core_ok, 1);

    // T2: lock 5 cycles into WAIT_LOCK, core released 11 cycles later
    repeat (5) @(negedge refclk);
    pll_locked = 1'b1;
    push(EV_READY, 0, 0, cyc);
    wait_ready("t2", 40);

    // T3: lock glitch mid-STABLE restarts the stable count
    do_reset("t3_reset");
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (6) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    push(EV_READY, 0, 0, cyc);
    repeat (4) @(negedge refclk);
    chk("t3_core_rst_not_early", int'(core_rst), 1);
    wait_ready("t3", 40);

    // T5: 300 lock losses in RUN, relock_cnt saturates at 255
    for (int i = 0; i < 300; i++) begin
      r_exp = (i + 1 > 255) ? 255 : i + 1;
      @(negedge refclk);
      pll_locked = 1'b0;
      push(EV_LL, 0, r_exp, -1);
      push(EV_READY, 0, r_exp, -1);
      repeat (3) @(negedge refclk);
      pll_locked = 1'b1;
      wait_ready("t5", 60);
    end
    chk("t5_relock_saturated", int'(relock_cnt), 255);

    // T4: lock stuck low for 100 cycles, 24-cycle retry period
    do_reset("t4_reset");
    for (int t = 1; t <= 4; t++) push(EV_TO, t, 0, -1);
    rises  = 0;
    prev_p = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge refclk);
      if (pll_rst && prev_p == 0) rises++;
      prev_p = int'(pll_rst);
    end
    chk("t4_timeout_cnt", int'(timeout_cnt), 4);
    chk("t4_pll_rst_pulses", rises, 4);

    // T6: asynchronous rst between edges while in STABLE
    pll_locked = 1'b1;
    repeat (4) @(negedge refclk);
    chk("t6_pre_core_rst", int'(core_rst), 1);
    chk("t6_pre_timeout_cnt", int'(timeout_cnt), 4);
    @(posedge refclk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_pll_rst", int'(pll_rst), 1);
    chk("t6_core_rst", int'(core_rst), 1);
    chk("t6_ready", int'(ready), 0);
    chk("t6_lock_lost", int'(lock_lost), 0);
    chk("t6_timeout_cnt", int'(timeout_cnt), 0);
    chk("t6_relock_cnt", int'(relock_cnt), 0);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
